tipi_shift_ctrl: RTL and testbench
==================================

# tipi_shift_ctrl

Clock-domain controller for the TIPI RPi serial register port. It synchronises the RPi's asynchronous shift clock, latch-enable, register-select and serial data into `clk`, detects shift-clock rising edges, and sequences four 8-bit registers. Two are RPi→TI receive registers (data and control); two are TI→RPi transmit registers (data and control). It also keeps per-channel bit counters for frame checking and a "new TI data" handshake flag. It sits between the RPi header pins and the TI-side data/control latches and DSR bus mux.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop stages on each RPi input, minimum 2.

Ports:
- `clk`  in  1: 50 MHz system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `rpi_regsel`  in  2: channel select. 00 = rx data, 01 = rx control, 10 = tx data, 11 = tx control.
- `rpi_le`  in  1: latch enable, sampled on shift-clock rise.
- `rpi_shclk`  in  1: RPi shift clock, asynchronous.
- `rpi_sdata_out`  in  1: serial bit from the RPi.
- `rpi_sdata_in`  out  1: serial bit to the RPi, registered.
- `td_in`  in  8: TI-written data latch value.
- `tc_in`  in  8: TI-written control latch value.
- `td_wr`  in  1: one-cycle pulse (in `clk` domain) when the TI writes `td_in`.
- `rd_out`  out  8: latched rx data, RPi→TI.
- `rc_out`  out  8: latched rx control, RPi→TI.
- `rd_upd`  out  1: one-cycle pulse when `rd_out` is latched.
- `rc_upd`  out  1: one-cycle pulse when `rc_out` is latched.
- `td_new`  out  1: TI data written but not yet fetched by the RPi.
- `frame_err`  out  1: sticky error flag; a latch occurred with a bit count other than 8.
- `err_clr`  in  1: clears `frame_err`.

## Operation
Synchronisation and edge detection:
- `rpi_shclk`, `rpi_le`, `rpi_regsel` and `rpi_sdata_out` each pass through `SYNC_STAGES` flops.
- An event is synced `shclk` high while a registered copy of it is low.
- On an event, the synced `regsel`, `le` and `sdata` values are used.

Rx channels (00, 01). Each has an internal shift register `sh` and a 4-bit counter `cnt`.
- `le`=0: `sh <= {sh[6:0], sdata}`; `cnt` increments, saturating at 15.
- `le`=1:
  - the output register (`rd_out` or `rc_out`) takes `sh`;
  - the matching `_upd` pulse is asserted;
  - if `cnt != 8`, `frame_err` is set;
  - `cnt` goes to 0;
  - `sh` is unchanged.

Tx channels (10, 11). Each has an internal shift register `tsh` and a counter `tcnt`.
- `le`=1: `tsh` loads `td_in` or `tc_in`; `tcnt` goes to 0.
- `le`=0: `tsh <= {tsh[6:0], 1'b0}`; `tcnt` increments, saturating at 15.
- A tx latch with `tcnt` between 1 and 6 sets `frame_err`. This is an aborted previous frame.
- After any tx event, `rpi_sdata_in <= tsh[7]` of the updated register, on the same edge.
- The RPi protocol per byte is: latch, read bit 7, then 7× (shift, read). That yields MSB first.

Per-channel state machine, one per channel: `IDLE` → `ACTIVE` → `IDLE`.
- Rx: `IDLE` → `ACTIVE` on the first shift. `ACTIVE` → `IDLE` on latch.
- Tx: `IDLE` → `ACTIVE` on latch. `ACTIVE` → `IDLE` when `tcnt` reaches 7.
- State affects only `frame_err` and `td_new`.

Handshake and error clearing:
- `td_new` is set by `td_wr`.
- `td_new` is cleared by a tx-data latch event.
- If both happen in the same cycle, set wins.
- `err_clr` clears `frame_err`. If an error sets in the same cycle, set wins.

Unselected channels hold all state.

## Timing
- Reset (asynchronous, any time, including mid-frame) clears:
  - all shift registers, counters and outputs, including `rpi_sdata_in`, `rd_out`, `rc_out`, `rd_upd`, `rc_upd`, `td_new` and `frame_err`;
  - all states to `IDLE`;
  - the synchroniser chains.
- Event latency: register updates occur on the (`SYNC_STAGES`+1)th `clk` rise after the first rise that samples `rpi_shclk` high. `rpi_sdata_in` updates on that same edge.
- `_upd` pulses last exactly one `clk` cycle.
- RPi requirements:
  - `regsel`, `le` and `sdata_out` stable from ≥ 1 `clk` before to ≥ `SYNC_STAGES`+2 `clk` after the `shclk` rise;
  - `shclk` high and low each ≥ `SYNC_STAGES`+1 `clk`.
- `td_in`/`tc_in` are sampled on the event cycle.
- No event is generated while `rpi_shclk` is held high.

## Test plan
- Rx data frame: regsel 00, shift bits 1,0,1,0,0,1,0,1, then latch → `rd_out`=0xA5, one `rd_upd` pulse, `frame_err`=0, `rc_out` unchanged at 0x00.
- Tx control frame: `tc_in`=0x3C, regsel 11, latch, then 7 shifts → `rpi_sdata_in` reads 0,0,1,1,1,1,0,0 after each event, with latency `SYNC_STAGES`+1.
- Handshake: `td_wr` pulse → `td_new`=1; a tx-data latch in the same cycle as a second `td_wr` → `td_new` stays 1; next tx-data latch → `td_new`=0.
- Frame error: 5 shifts then latch on regsel 01 → `rc_out` updated, `frame_err`=1; `err_clr` → 0.
- Reset mid-frame: assert `rst_n`=0 after 4 rx shifts → all outputs 0 immediately; after release, a full 8-bit frame latches correctly with `frame_err`=0.
- Glitch-free sync: `rpi_shclk` held high for 20 cycles → exactly one event; regsel change while `shclk` is low → no event.

Source files
------------

// File: rtl/tipi_shift_ctrl_if.sv
// tipi_shift_ctrl_if
// Bundles the RPi serial port pins and the TI-side latch/handshake signals
// of the TIPI shift controller.
//   master : the environment (RPi header + TI latches) driving the controller
//   slave  : the controller itself
// Signals:
//   rpi_regsel[1:0], rpi_le, rpi_shclk, rpi_sdata_out : RPi -> controller
//   rpi_sdata_in                                      : controller -> RPi
//   td_in[7:0], tc_in[7:0], td_wr, err_clr            : TI side -> controller
//   rd_out[7:0], rc_out[7:0], rd_upd, rc_upd,
//   td_new, frame_err                                 : controller -> TI side
interface tipi_shift_ctrl_if;
  logic [1:0] rpi_regsel;
  logic       rpi_le;
  logic       rpi_shclk;
  logic       rpi_sdata_out;
  logic       rpi_sdata_in;
  logic [7:0] td_in;
  logic [7:0] tc_in;
  logic       td_wr;
  logic [7:0] rd_out;
  logic [7:0] rc_out;
  logic       rd_upd;
  logic       rc_upd;
  logic       td_new;
  logic       frame_err;
  logic       err_clr;

  modport master (
    output rpi_regsel, rpi_le, rpi_shclk, rpi_sdata_out,
    output td_in, tc_in, td_wr, err_clr,
    input  rpi_sdata_in, rd_out, rc_out, rd_upd, rc_upd, td_new, frame_err
  );

  modport slave (
    input  rpi_regsel, rpi_le, rpi_shclk, rpi_sdata_out,
    input  td_in, tc_in, td_wr, err_clr,
    output rpi_sdata_in, rd_out, rc_out, rd_upd, rc_upd, td_new, frame_err
  );
endinterface

// File: rtl/tipi_shift_ctrl.sv
// tipi_shift_ctrl
// Clock-domain controller for the TIPI RPi serial register port. The RPi's
// asynchronous shift clock, latch enable, register select and serial data are
// synchronised into clk; each rising edge of the synchronised shift clock is
// one "event" that either shifts or latches the selected channel:
//   regsel 00 : rx data    (RPi -> TI, lands in rd_out, pulses rd_upd)
//   regsel 01 : rx control (RPi -> TI, lands in rc_out, pulses rc_upd)
//   regsel 10 : tx data    (TI td_in -> RPi, MSB first on rpi_sdata_in)
//   regsel 11 : tx control (TI tc_in -> RPi, MSB first on rpi_sdata_in)
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : tipi_shift_ctrl_if.slave (RPi pins, TI latches, handshake, errors)
// Parameter:
//   SYNC_STAGES : synchroniser depth on every RPi input (>= 2)
module tipi_shift_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  tipi_shift_ctrl_if.slave bus
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    if (v == 4'd15) begin
      return 4'd15;
    end else begin
      return v + 4'd1;
    end
  endfunction

  // Raw RPi inputs packed as {regsel[1:0], le, sdata, shclk}
  logic [4:0]                  raw_s;
  logic [SYNC_STAGES-1:0][4:0] sync_r;
  logic [4:0]                  synced_s;
  logic                        shclk_s;
  logic                        sdata_s;
  logic                        le_s;
  logic [1:0]                  regsel_s;
  logic                        shclk_q_r;
  logic                        ev_s;
  logic                        ch_s;

  logic [1:0][7:0] rx_sh_r,  rx_sh_nxt_s;
  logic [1:0][3:0] rx_cnt_r, rx_cnt_nxt_s;
  logic [1:0]      rx_st_r,  rx_st_nxt_s;
  logic [1:0][7:0] tx_sh_r,  tx_sh_nxt_s;
  logic [1:0][3:0] tx_cnt_r, tx_cnt_nxt_s;
  logic [1:0]      tx_st_r,  tx_st_nxt_s;

  logic [7:0] rd_out_r, rd_out_nxt_s;
  logic [7:0] rc_out_r, rc_out_nxt_s;
  logic       rd_upd_r, rd_upd_nxt_s;
  logic       rc_upd_r, rc_upd_nxt_s;
  logic       td_new_r, td_new_nxt_s;
  logic       frame_err_r, frame_err_nxt_s;
  logic       sdata_in_r, sdata_in_nxt_s;
  logic       err_set_s;
  logic       td_clr_s;

  assign raw_s    = {bus.rpi_regsel, bus.rpi_le, bus.rpi_sdata_out, bus.rpi_shclk};
  assign synced_s = sync_r[SYNC_STAGES-1];
  assign shclk_s  = synced_s[0];
  assign sdata_s  = synced_s[1];
  assign le_s     = synced_s[2];
  assign regsel_s = synced_s[4:3];
  // Rising edge of the synchronised shift clock; a held-high clock yields one event
  assign ev_s     = shclk_s & ~shclk_q_r;
  assign ch_s     = regsel_s[0];

  // Synchroniser chains for all RPi inputs plus the edge-detect history flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r    <= '0;
      shclk_q_r <= 1'b0;
    end else begin
      sync_r    <= {sync_r[SYNC_STAGES-2:0], raw_s};
      shclk_q_r <= shclk_s;
    end
  end

  // Next-state logic for the four channels, outputs, handshake and error flag
  always_comb begin
    rx_sh_nxt_s  = rx_sh_r;
    rx_cnt_nxt_s = rx_cnt_r;
    rx_st_nxt_s  = rx_st_r;
    tx_sh_nxt_s  = tx_sh_r;
    tx_cnt_nxt_s = tx_cnt_r;
    tx_st_nxt_s  = tx_st_r;
    rd_out_nxt_s = rd_out_r;
    rc_out_nxt_s = rc_out_r;
    rd_upd_nxt_s = 1'b0;
    rc_upd_nxt_s = 1'b0;
    err_set_s    = 1'b0;
    td_clr_s     = 1'b0;
    sdata_in_nxt_s = sdata_in_r;

    if (ev_s) begin
      case (regsel_s)
        2'b00, 2'b01: begin
          if (le_s) begin
            if (ch_s == 1'b0) begin
              rd_out_nxt_s = rx_sh_r[0];
              rd_upd_nxt_s = 1'b1;
            end else begin
              rc_out_nxt_s = rx_sh_r[1];
              rc_upd_nxt_s = 1'b1;
            end
            if (rx_cnt_r[ch_s] != 4'd8) begin
              err_set_s = 1'b1;
            end else begin
              err_set_s = 1'b0;
            end
            rx_cnt_nxt_s[ch_s] = 4'd0;
            rx_st_nxt_s[ch_s]  = ST_IDLE;
          end else begin
            rx_sh_nxt_s[ch_s]  = {rx_sh_r[ch_s][6:0], sdata_s};
            rx_cnt_nxt_s[ch_s] = sat_inc(rx_cnt_r[ch_s]);
            rx_st_nxt_s[ch_s]  = ST_ACTIVE;
          end
        end
        2'b10, 2'b11: begin
          if (le_s) begin
            // Latching while 1..6 bits of the previous byte were read aborts it
            if ((tx_cnt_r[ch_s] >= 4'd1) && (tx_cnt_r[ch_s] <= 4'd6)) begin
              err_set_s = 1'b1;
            end else begin
              err_set_s = 1'b0;
            end
            if (ch_s == 1'b0) begin
              tx_sh_nxt_s[0] = bus.td_in;
              td_clr_s       = 1'b1;
            end else begin
              tx_sh_nxt_s[1] = bus.tc_in;
              td_clr_s       = 1'b0;
            end
            tx_cnt_nxt_s[ch_s] = 4'd0;
            tx_st_nxt_s[ch_s]  = ST_ACTIVE;
          end else begin
            tx_sh_nxt_s[ch_s]  = {tx_sh_r[ch_s][6:0], 1'b0};
            tx_cnt_nxt_s[ch_s] = sat_inc(tx_cnt_r[ch_s]);
            if ((tx_st_r[ch_s] == ST_ACTIVE) && (tx_cnt_nxt_s[ch_s] == 4'd7)) begin
              tx_st_nxt_s[ch_s] = ST_IDLE;
            end else begin
              tx_st_nxt_s[ch_s] = tx_st_r[ch_s];
            end
          end
          // The RPi samples the MSB of the freshly updated register
          sdata_in_nxt_s = tx_sh_nxt_s[ch_s][7];
        end
        default: begin
          err_set_s = 1'b0;
        end
      endcase
    end else begin
      err_set_s = 1'b0;
    end

    // Set beats clear on both sticky flags
    td_new_nxt_s    = bus.td_wr | (td_new_r & ~td_clr_s);
    frame_err_nxt_s = err_set_s | (frame_err_r & ~bus.err_clr);
  end

  // Channel state, output registers and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sh_r     <= '0;
      rx_cnt_r    <= '0;
      rx_st_r     <= {ST_IDLE, ST_IDLE};
      tx_sh_r     <= '0;
      tx_cnt_r    <= '0;
      tx_st_r     <= {ST_IDLE, ST_IDLE};
      rd_out_r    <= 8'h00;
      rc_out_r    <= 8'h00;
      rd_upd_r    <= 1'b0;
      rc_upd_r    <= 1'b0;
      td_new_r    <= 1'b0;
      frame_err_r <= 1'b0;
      sdata_in_r  <= 1'b0;
    end else begin
      rx_sh_r     <= rx_sh_nxt_s;
      rx_cnt_r    <= rx_cnt_nxt_s;
      rx_st_r     <= rx_st_nxt_s;
      tx_sh_r     <= tx_sh_nxt_s;
      tx_cnt_r    <= tx_cnt_nxt_s;
      tx_st_r     <= tx_st_nxt_s;
      rd_out_r    <= rd_out_nxt_s;
      rc_out_r    <= rc_out_nxt_s;
      rd_upd_r    <= rd_upd_nxt_s;
      rc_upd_r    <= rc_upd_nxt_s;
      td_new_r    <= td_new_nxt_s;
      frame_err_r <= frame_err_nxt_s;
      sdata_in_r  <= sdata_in_nxt_s;
    end
  end

  assign bus.rpi_sdata_in = sdata_in_r;
  assign bus.rd_out       = rd_out_r;
  assign bus.rc_out       = rc_out_r;
  assign bus.rd_upd       = rd_upd_r;
  assign bus.rc_upd       = rc_upd_r;
  assign bus.td_new       = td_new_r;
  assign bus.frame_err    = frame_err_r;

endmodule

// File: tb/tb_tipi_shift_ctrl.sv
// tb_tipi_shift_ctrl
// Self-checking bench for tipi_shift_ctrl: directed scenarios followed by
// randomized shift/latch traffic, compared against a byte/bit-count model.
module tb_tipi_shift_ctrl;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  tipi_shift_ctrl_if bus ();

  tipi_shift_ctrl #(.SYNC_STAGES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bytes seen so far and bits read per channel
  int m_rx_sh [2];
  int m_rx_cnt[2];
  int m_tx_byte[2];
  int m_tx_k  [2];
  int m_rd, m_rc, m_err, m_tdnew, m_sdin;
  int exp_rd_upd, exp_rc_upd;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_rd_out"},    32'(bus.rd_out),       m_rd);
    check_eq({tag, "_rc_out"},    32'(bus.rc_out),       m_rc);
    check_eq({tag, "_frame_err"}, 32'(bus.frame_err),    m_err);
    check_eq({tag, "_td_new"},    32'(bus.td_new),       m_tdnew);
    check_eq({tag, "_sdata_in"},  32'(bus.rpi_sdata_in), m_sdin);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_rx_sh[i] = 0; m_rx_cnt[i] = 0; m_tx_byte[i] = 0; m_tx_k[i] = 0;
    end
    m_rd = 0; m_rc = 0; m_err = 0; m_tdnew = 0; m_sdin = 0;
  endtask

  task automatic model_event(input int rs, input int le, input int sd,
                             input int tdin, input int tcin, input int wr);
    int ch;
    ch = rs % 2;
    exp_rd_upd = 0;
    exp_rc_upd = 0;
    if (rs < 2) begin
      if (le != 0) begin
        if (ch == 0) begin m_rd = m_rx_sh[0]; exp_rd_upd = 1; end
        else         begin m_rc = m_rx_sh[1]; exp_rc_upd = 1; end
        if (m_rx_cnt[ch] != 8) m_err = 1;
        m_rx_cnt[ch] = 0;
      end else begin
        m_rx_sh[ch]  = (m_rx_sh[ch] * 2 + sd) % 256;
        m_rx_cnt[ch] = (m_rx_cnt[ch] < 15) ? m_rx_cnt[ch] + 1 : 15;
      end
    end else begin
      if (le != 0) begin
        if (m_tx_k[ch] >= 1 && m_tx_k[ch] <= 6) m_err = 1;
        m_tx_byte[ch] = (ch == 1) ? tcin : tdin;
        m_tx_k[ch] = 0;
        if (ch == 0) m_tdnew = 0;
      end else begin
        m_tx_k[ch] = (m_tx_k[ch] < 15) ? m_tx_k[ch] + 1 : 15;
      end
      m_sdin = (m_tx_k[ch] < 8) ? ((m_tx_byte[ch] >> (7 - m_tx_k[ch])) & 1) : 0;
    end
    if (wr != 0) m_tdnew = 1;
  endtask

  // One RPi shift-clock pulse; wr puts a td_wr pulse on the event edge itself
  task automatic shift_event(input logic [1:0] rs, input logic le, input logic sd,
                             input logic [7:0] tdin, input logic [7:0] tcin,
                             input logic wr, input int hold);
    @(negedge clk);
    bus.rpi_regsel = rs; bus.rpi_le = le; bus.rpi_sdata_out = sd;
    bus.td_in = tdin; bus.tc_in = tcin;
    @(negedge clk);
    bus.rpi_shclk = 1'b1;
    repeat (S) @(posedge clk);
    #1;
    check_eq("early_sdata_in", 32'(bus.rpi_sdata_in), m_sdin);
    check_eq("early_rd_upd", 32'(bus.rd_upd), 0);
    check_eq("early_rc_upd", 32'(bus.rc_upd), 0);
    @(negedge clk);
    bus.td_wr = wr;
    @(posedge clk);
    #1;
    bus.td_wr = 1'b0;
    model_event(int'(rs), int'(le), int'(sd), int'(tdin), int'(tcin), int'(wr));
    check_all("event");
    check_eq("rd_upd", 32'(bus.rd_upd), exp_rd_upd);
    check_eq("rc_upd", 32'(bus.rc_upd), exp_rc_upd);
    @(posedge clk);
    #1;
    check_eq("rd_upd_width", 32'(bus.rd_upd), 0);
    check_eq("rc_upd_width", 32'(bus.rc_upd), 0);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    bus.rpi_shclk = 1'b0;
    repeat (S + 1) @(negedge clk);
  endtask

  task automatic pulse_td_wr();
    @(negedge clk); bus.td_wr = 1'b1;
    @(negedge clk); bus.td_wr = 1'b0;
    m_tdnew = 1;
    check_eq("td_wr_td_new", 32'(bus.td_new), 1);
  endtask

  task automatic pulse_err_clr();
    @(negedge clk); bus.err_clr = 1'b1;
    @(negedge clk); bus.err_clr = 1'b0;
    m_err = 0;
    check_eq("err_clr_frame_err", 32'(bus.frame_err), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a5_bits;
    logic [7:0] tx_pat;
    bus.rpi_regsel = 2'b00; bus.rpi_le = 1'b0; bus.rpi_shclk = 1'b0;
    bus.rpi_sdata_out = 1'b0; bus.td_in = 8'h00; bus.tc_in = 8'h00;
    bus.td_wr = 1'b0; bus.err_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Rx data frame 0xA5
    a5_bits = 8'hA5;
    for (int i = 7; i >= 0; i--) shift_event(2'b00, 1'b0, a5_bits[i], 8'h00, 8'h00, 1'b0, 0);
    shift_event(2'b00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1);
    check_eq("a5_rd_out", 32'(bus.rd_out), 32'h0000_00A5);
    check_eq("a5_frame_err", 32'(bus.frame_err), 0);
    check_eq("a5_rc_out", 32'(bus.rc_out), 0);

    // Tx control frame 0x3C, MSB first
    tx_pat = 8'h3C;
    shift_event(2'b11, 1'b1, 1'b0, 8'h00, 8'h3C, 1'b0, 0);
    check_eq("tx3c_bit7", 32'(bus.rpi_sdata_in), 32'(tx_pat[7]));
    for (int i = 6; i >= 0; i--) begin
      shift_event(2'b11, 1'b0, 1'b0, 8'h00, 8'h3C, 1'b0, 0);
      check_eq("tx3c_bit", 32'(bus.rpi_sdata_in), 32'(tx_pat[i]));
    end
    check_eq("tx3c_frame_err", 32'(bus.frame_err), 0);

    // Handshake: set wins over a same-cycle tx-data latch
    pulse_td_wr();
    shift_event(2'b10, 1'b1, 1'b0, 8'h81, 8'h00, 1'b1, 0);
    check_eq("hs_same_cycle", 32'(bus.td_new), 1);
    shift_event(2'b10, 1'b1, 1'b0, 8'h42, 8'h00, 1'b0, 0);
    check_eq("hs_fetched", 32'(bus.td_new), 0);

    // Short rx control frame -> frame error
    for (int i = 0; i < 5; i++) shift_event(2'b01, 1'b0, 1'(i % 2), 8'h00, 8'h00, 1'b0, 0);
    shift_event(2'b01, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 0);
    check_eq("short_rc_out", 32'(bus.rc_out), 32'h0000_000A);
    check_eq("short_frame_err", 32'(bus.frame_err), 1);
    pulse_err_clr();

    // Shift clock held high 20 cycles counts once
    shift_event(2'b11, 1'b1, 1'b0, 8'h00, 8'h40, 1'b0, 0);
    shift_event(2'b11, 1'b0, 1'b0, 8'h00, 8'h40, 1'b0, 20);
    check_eq("held_high_one_event", 32'(bus.rpi_sdata_in), 1);
    // Select/data wiggling with the shift clock low does nothing
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.rpi_regsel = 2'($urandom_range(0, 3));
      bus.rpi_le = 1'($urandom_range(0, 1));
      bus.rpi_sdata_out = 1'($urandom_range(0, 1));
    end
    repeat (S + 2) @(negedge clk);
    check_all("no_event");

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      shift_event(2'($urandom_range(0, 3)), 1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 7) == 0), $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) pulse_err_clr();
      if ($urandom_range(0, 9) == 0) pulse_td_wr();
    end

    // Reset mid-frame
    pulse_td_wr();
    for (int i = 0; i < 4; i++) shift_event(2'b00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 0);
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    check_eq("rst_rd_out", 32'(bus.rd_out), 0);
    check_eq("rst_rc_out", 32'(bus.rc_out), 0);
    check_eq("rst_td_new", 32'(bus.td_new), 0);
    check_eq("rst_frame_err", 32'(bus.frame_err), 0);
    check_eq("rst_sdata_in", 32'(bus.rpi_sdata_in), 0);
    check_eq("rst_rd_upd", 32'(bus.rd_upd), 0);
    check_eq("rst_rc_upd", 32'(bus.rc_upd), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tx_pat = 8'h5B;
    for (int i = 7; i >= 0; i--) shift_event(2'b00, 1'b0, tx_pat[i], 8'h00, 8'h00, 1'b0, 0);
    shift_event(2'b00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 0);
    check_eq("post_rst_rd_out", 32'(bus.rd_out), 32'h0000_005B);
    check_eq("post_rst_frame_err", 32'(bus.frame_err), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
